hex_digit_scanner: RTL and testbench
====================================

HEX_DIGIT_SCANNER -- requirements
Module: hex_digit_scanner

Interface
REQ-001 Parameter PRESCALE, default 50000: clock cycles per digit slot; legal when PRESCALE >= GUARD+2.
REQ-002 Parameter GUARD, default 16: anode-off (anti-ghosting) cycles at the start of each slot; legal when GUARD >= 1.
REQ-003 Port clk, input, 1: single system clock; all logic rising-edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port data_in, input, 16: four hex digits; digit 3 = [15:12] (leftmost), digit 0 = [3:0].
REQ-006 Port blank_in, input, 4: per-digit force-blank mask, bit i blanks digit i.
REQ-007 Port lzs_in, input, 1: leading-zero suppression enable.
REQ-008 Port load, input, 1: one-cycle strobe capturing data_in, blank_in and lzs_in.
REQ-009 Port hex_out, output, 4: nibble of the currently scanned digit; feeds the hex-to-segment decoder.
REQ-010 Port an, output, 4: active-low digit anode enables.
REQ-011 Port frame_done, output, 1: one-cycle pulse at the end of every 4-digit frame.

Function
REQ-012 Slot counter cnt SHALL count 0..PRESCALE-1 and wrap to 0; on wrap, digit index idx SHALL advance 0->1->2->3->0.
REQ-013 FSM SHALL have two states: GUARD while cnt < GUARD, ACTIVE while cnt >= GUARD; GUARD->ACTIVE when cnt reaches GUARD; ACTIVE->GUARD on cnt wrap.
REQ-014 hex_out SHALL be registered, equal disp[4*idx+3:4*idx], and be valid from cnt=0 of each slot, i.e. at least GUARD cycles before the anode turns on.
REQ-015 In GUARD, an SHALL be 4'b1111.
REQ-016 In ACTIVE, an[idx] SHALL be 0 unless digit idx is blanked; all other an bits SHALL be 1.
REQ-017 Digit i SHALL be blanked when disp_blank[i]=1, or when disp_lzs=1, i>0 and every nibble from i up to 3 is zero; digit 0 is never suppressed by LZS.
REQ-018 load SHALL write data_in/blank_in/lzs_in into shadow registers on the same edge.
REQ-019 At frame boundary (idx=3, cnt=PRESCALE-1), shadow SHALL be copied to the display registers (disp, disp_blank, disp_lzs) on that edge; if load is high in that same cycle, data_in/blank_in/lzs_in SHALL be copied directly (bypass) and also written to shadow.
REQ-020 Display registers SHALL change only at frame boundaries, so no frame shows mixed old/new values.
REQ-021 frame_done SHALL be registered and high for exactly the cycle after the frame-boundary edge (idx=0, cnt=0 of the next frame).
REQ-022 load during reset SHALL be ignored.

Reset
REQ-023 On rst sampled high: cnt=0, idx=0, state=GUARD, an=4'b1111, hex_out=4'h0, frame_done=0; shadow and display registers = 0, blank = 4'b0000, lzs = 0.
REQ-024 Reset asserted mid-slot or mid-frame SHALL take effect on the next edge regardless of state; the first slot after release is digit 0 starting at cnt=0.

Structure
REQ-025 Shared package/include hex_disp_pkg SHALL hold NUM_DIGITS=4, DIGIT_W=4 and the GUARD/ACTIVE state encodings.
REQ-026 The prescaler SHALL be a sub-module slot_timer (cnt, wrap pulse, GUARD flag), parameterised by PRESCALE and GUARD.
REQ-027 Expected RTL size: 120-400 lines; no latches; every output driven from a flop.

Verification (PRESCALE=8, GUARD=2)
REQ-028 Reset, then load 16'h1A2F, blank 0, lzs 0 -> from the second frame on, hex_out sequence F,2,A,1 per 8-cycle slot; an=1111 for 2 cycles then 1110/1101/1011/0111 for 6 cycles each.
REQ-029 Load 16'h0005, lzs=1 -> digits 3..1 have an=1111 all slot; digit 0 shows 5 with an=1110; load 16'h0000, lzs=1 -> only digit 0 lit, showing 0.
REQ-030 Load 16'hBEEF mid-frame -> current frame unchanged; new value appears starting at the next idx=0 slot; frame_done pulses once per 32 cycles.
REQ-031 load 16'h1234 asserted exactly in the boundary cycle -> the next frame displays 1234 (bypass); blank_in=4'b0100 -> digit 2 an stays 1 in ACTIVE.
REQ-032 rst pulsed in cycle 13 of a frame -> next cycle an=1111, hex_out=0, frame_done=0; display restarts at digit 0, cnt 0, all-zero data.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared constants, FSM encoding and blanking helper for the 4-digit hex scanner.
package hex_disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int DATA_W     = NUM_DIGITS * DIGIT_W;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  typedef enum logic {
    ST_GUARD  = 1'b0,
    ST_ACTIVE = 1'b1
  } scan_state_e;

  // A digit is dark when force-blanked, or (LZS on) it and everything to its left is zero.
  function automatic logic [NUM_DIGITS-1:0] digit_blank_mask(
    input logic [DATA_W-1:0]     disp,
    input logic [NUM_DIGITS-1:0] blank,
    input logic                  lzs
  );
    logic [NUM_DIGITS-1:0] mask;
    logic                  upper_zero;
    mask       = blank;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (disp[i*DIGIT_W +: DIGIT_W] == '0);
      mask[i]    = mask[i] | (lzs & upper_zero);
    end
    return mask;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-digit slot prescaler: counts 0..PRESCALE-1, flags the wrap and the last guard cycle.
module slot_timer #(
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [$clog2(PRESCALE)-1:0] cnt,
  output logic                        wrap,
  output logic                        guard_end
);

  localparam int CNT_W = $clog2(PRESCALE);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    wrap      = (cnt_q == CNT_W'(PRESCALE - 1));
    guard_end = (cnt_q == CNT_W'(GUARD - 1));
    cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hex_digit_scanner.sv
// Time-multiplexed 4-digit hex display scanner with anti-ghosting guard,
// frame-synchronous double buffering and leading-zero suppression.
module hex_digit_scanner
  import hex_disp_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [NUM_DIGITS-1:0] blank_in,
  input  logic                  lzs_in,
  input  logic                  load,
  output logic [DIGIT_W-1:0]    hex_out,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(PRESCALE);

  logic [CNT_W-1:0]      cnt;
  logic                  wrap;
  logic                  guard_end;
  logic                  boundary;

  logic [IDX_W-1:0]      idx_q, idx_d;
  scan_state_e           state_q, state_d;
  logic [DATA_W-1:0]     shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] shadow_blank_q, shadow_blank_d;
  logic                  shadow_lzs_q, shadow_lzs_d;
  logic [DATA_W-1:0]     disp_q, disp_d;
  logic [NUM_DIGITS-1:0] disp_blank_q, disp_blank_d;
  logic                  disp_lzs_q, disp_lzs_d;
  logic [DIGIT_W-1:0]    hex_q, hex_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] dark_mask;

  slot_timer #(
    .PRESCALE (PRESCALE),
    .GUARD    (GUARD)
  ) u_slot_timer (
    .clk       (clk),
    .rst       (rst),
    .cnt       (cnt),
    .wrap      (wrap),
    .guard_end (guard_end)
  );

  always_comb begin
    boundary = (idx_q == IDX_W'(NUM_DIGITS - 1)) && (cnt == CNT_W'(PRESCALE - 1));
    idx_d    = wrap ? idx_q + IDX_W'(1) : idx_q;

    shadow_d       = shadow_q;
    shadow_blank_d = shadow_blank_q;
    shadow_lzs_d   = shadow_lzs_q;
    if (load) begin
      shadow_d       = data_in;
      shadow_blank_d = blank_in;
      shadow_lzs_d   = lzs_in;
    end

    // Display regs move only on the frame edge; a load landing on that edge bypasses the shadow.
    disp_d       = disp_q;
    disp_blank_d = disp_blank_q;
    disp_lzs_d   = disp_lzs_q;
    if (boundary) begin
      disp_d       = load ? data_in  : shadow_q;
      disp_blank_d = load ? blank_in : shadow_blank_q;
      disp_lzs_d   = load ? lzs_in   : shadow_lzs_q;
    end

    state_d = state_q;
    case (state_q)
      ST_GUARD:  if (guard_end) state_d = ST_ACTIVE;
      ST_ACTIVE: if (wrap)      state_d = ST_GUARD;
      default:                  state_d = ST_GUARD;
    endcase

    dark_mask    = digit_blank_mask(disp_d, disp_blank_d, disp_lzs_d);
    hex_d        = disp_d[idx_d*DIGIT_W +: DIGIT_W];
    frame_done_d = boundary;
  end

  // Outputs are computed from next-cycle state so the registered values line up with cnt/idx.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign an_d[gi] = !((state_d == ST_ACTIVE) && (idx_d == IDX_W'(gi)) && !dark_mask[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q          <= '0;
      state_q        <= ST_GUARD;
      shadow_q       <= '0;
      shadow_blank_q <= '0;
      shadow_lzs_q   <= 1'b0;
      disp_q         <= '0;
      disp_blank_q   <= '0;
      disp_lzs_q     <= 1'b0;
      hex_q          <= '0;
      an_q           <= '1;
      frame_done_q   <= 1'b0;
    end else begin
      idx_q          <= idx_d;
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      shadow_blank_q <= shadow_blank_d;
      shadow_lzs_q   <= shadow_lzs_d;
      disp_q         <= disp_d;
      disp_blank_q   <= disp_blank_d;
      disp_lzs_q     <= disp_lzs_d;
      hex_q          <= hex_d;
      an_q           <= an_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign hex_out    = hex_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Self-checking bench for hex_digit_scanner (PRESCALE=8, GUARD=2): vector table,
// corner-case sequences and random stimulus against a frame-position reference model.
module tb_hex_digit_scanner;

  localparam int P     = 8;
  localparam int G     = 2;
  localparam int FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  blank_in;
  logic        lzs_in;
  logic        load;
  logic [3:0]  hex_out;
  logic [3:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  hex_digit_scanner #(
    .PRESCALE (P),
    .GUARD    (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .blank_in   (blank_in),
    .lzs_in     (lzs_in),
    .load       (load),
    .hex_out    (hex_out),
    .an         (an),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position within the frame plus the two register banks.
  int          m_pos;
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_sblank, m_dblank;
  logic        m_slzs, m_dlzs, m_fd;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  blank;
    logic        lzs;
    logic [15:0] hex_exp;  // nibble s = expected hex_out in slot s
    logic [15:0] an_exp;   // nibble s = expected an in ACTIVE part of slot s
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s t=%0t pos=%0d actual=%h required=%h", name, $time, m_pos, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_hex();
    int idx = m_pos / P;
    return 4'((m_disp >> (4 * idx)) & 16'hF);
  endfunction

  function automatic logic [3:0] exp_an();
    int   idx = m_pos / P;
    int   c   = m_pos % P;
    logic dark;
    logic [3:0] r;
    if (c < G) return 4'hF;
    dark = m_dblank[idx] || (m_dlzs && idx > 0 && (m_disp >> (4 * idx)) == 16'h0);
    r = 4'hF;
    if (!dark) r[idx] = 1'b0;
    return r;
  endfunction

  task automatic model_edge();
    logic        boundary;
    logic [15:0] old_sh;
    logic [3:0]  old_sb;
    logic        old_sl;
    if (rst) begin
      m_pos = 0; m_shadow = 0; m_disp = 0; m_sblank = 0; m_dblank = 0;
      m_slzs = 0; m_dlzs = 0; m_fd = 0;
    end else begin
      boundary = (m_pos == FRAME - 1);
      old_sh = m_shadow; old_sb = m_sblank; old_sl = m_slzs;
      if (load) begin
        m_shadow = data_in; m_sblank = blank_in; m_slzs = lzs_in;
      end
      if (boundary) begin
        m_disp   = load ? data_in  : old_sh;
        m_dblank = load ? blank_in : old_sb;
        m_dlzs   = load ? lzs_in   : old_sl;
      end
      m_pos = (m_pos + 1) % FRAME;
      m_fd  = boundary;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("hex_out", hex_out, exp_hex());
    check("an", an, exp_an());
    check("frame_done", {3'b0, frame_done}, {3'b0, m_fd});
  endtask

  task automatic run_to(input int p);
    int b = 0;
    while (m_pos != p && b < 2 * FRAME) begin
      tick();
      b++;
    end
    check_int("run_to_timeout", m_pos, p);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic l);
    data_in = d; blank_in = b; lzs_in = l; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int fd_count;

    tbl[0] = '{16'h1A2F, 4'b0000, 1'b0, 16'h1A2F, 16'h7BDE};
    tbl[1] = '{16'h0005, 4'b0000, 1'b1, 16'h0005, 16'hFFFE};
    tbl[2] = '{16'h0000, 4'b0000, 1'b1, 16'h0000, 16'hFFFE};
    tbl[3] = '{16'h1234, 4'b0100, 1'b0, 16'h1234, 16'h7FDE};
    tbl[4] = '{16'h0F00, 4'b0000, 1'b1, 16'h0F00, 16'hFBDE};
    tbl[5] = '{16'hBEEF, 4'b1001, 1'b1, 16'hBEEF, 16'hFBDF};

    rst = 1'b1; load = 1'b0; data_in = 16'h0; blank_in = 4'h0; lzs_in = 1'b0;
    m_pos = 0;
    tick();
    check("reset_an", an, 4'hF);
    check("reset_hex", hex_out, 4'h0);
    tick();
    rst = 1'b0;

    // Vector table: load mid-frame, then check the whole following frame.
    for (int k = 0; k < 6; k++) begin
      run_to(5);
      do_load(tbl[k].data, tbl[k].blank, tbl[k].lzs);
      run_to(0);
      for (int s = 0; s < 4; s++) begin
        run_to(s * P + 4);
        check($sformatf("tbl%0d_hex_s%0d", k, s), hex_out, tbl[k].hex_exp[4*s +: 4]);
        check($sformatf("tbl%0d_an_s%0d", k, s), an, tbl[k].an_exp[4*s +: 4]);
      end
      $display("vector %0d data=%h blank=%b lzs=%b checked", k, tbl[k].data, tbl[k].blank, tbl[k].lzs);
    end

    // Mid-frame load must not disturb the frame in progress.
    run_to(5);
    do_load(16'h1A2F, 4'h0, 1'b0);
    run_to(0);
    run_to(13);
    do_load(16'hBEEF, 4'h0, 1'b0);
    run_to(20);
    check("midload_old_d2", hex_out, 4'hA);
    run_to(28);
    check("midload_old_d3", hex_out, 4'h1);
    run_to(4);
    check("midload_new_d0", hex_out, 4'hF);
    run_to(28);
    check("midload_new_d3", hex_out, 4'hB);
    fd_count = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (frame_done) fd_count++;
    end
    check_int("frame_done_per_64", fd_count, 2);
    $display("mid-frame load sequence done");

    // Load exactly in the boundary cycle: bypass into the next frame.
    run_to(FRAME - 1);
    data_in = 16'h1234; blank_in = 4'b0100; lzs_in = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    check("bypass_frame_done", {3'b0, frame_done}, 4'h1);
    run_to(4);
    check("bypass_d0_hex", hex_out, 4'h4);
    run_to(12);
    check("bypass_d1_hex", hex_out, 4'h3);
    check("bypass_d1_an", an, 4'hD);
    run_to(20);
    check("bypass_d2_an_blank", an, 4'hF);
    run_to(0);
    run_to(28);
    check("bypass_shadow_d3", hex_out, 4'h1);
    $display("boundary bypass sequence done");

    // Reset mid-frame, with a load held during reset that must be ignored.
    run_to(13);
    rst = 1'b1; data_in = 16'hFFFF; load = 1'b1;
    tick();
    check("midrst_an", an, 4'hF);
    check("midrst_hex", hex_out, 4'h0);
    check("midrst_fd", {3'b0, frame_done}, 4'h0);
    rst = 1'b0; load = 1'b0;
    run_to(4);
    check("postrst_d0_an", an, 4'hE);
    check("postrst_d0_hex", hex_out, 4'h0);
    run_to(0);
    run_to(28);
    check("postrst_d3_hex", hex_out, 4'h0);
    check("postrst_d3_an", an, 4'h7);
    $display("mid-frame reset sequence done");

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      data_in  = 16'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      lzs_in   = 1'($urandom);
      if ($urandom_range(0, 3) == 0) data_in = data_in & 16'h00FF;
      load     = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; load = 1'b0;
    tick();
    $display("random phase done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
